execute_unit: RTL and testbench

Execute stage directly downstream of the dual-read-port register file. It consumes the two operand words that the register file presents one cycle after the read addresses are issued. It performs one ALU or multi-cycle multiply operation and drives the register file write port (write enable, write address, write data) to write back the result. Single-cycle operations complete with one-cycle latency. MUL uses an iterative shift-add datapath and holds off upstream with a busy flag.

---
 rtl/execute_unit_pkg.sv | 21 ++
 rtl/shift_add_multiplier.sv | 53 +++++
 rtl/execute_unit.sv | 120 ++++++++++++
 tb/tb_execute_unit.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/execute_unit_pkg.sv
// Shared opcode and FSM state definitions for the execute stage.
package execute_unit_pkg;

  typedef enum logic [2:0] {
    OP_NOP = 3'd0,
    OP_ADD = 3'd1,
    OP_SUB = 3'd2,
    OP_AND = 3'd3,
    OP_OR  = 3'd4,
    OP_XOR = 3'd5,
    OP_SRL = 3'd6,
    OP_MUL = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_WB   = 2'd2
  } state_e;

endpackage

// File: rtl/shift_add_multiplier.sv
// Iterative unsigned shift-add multiplier; one partial product per cycle,
// low DATA_WIDTH bits of the product only.
module shift_add_multiplier #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] operand_a,
  input  logic [DATA_WIDTH-1:0] operand_b,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] product
);

  localparam int unsigned CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  logic                  active;
  logic [CW-1:0]         count;
  logic [DATA_WIDTH-1:0] multiplicand;
  logic [DATA_WIDTH-1:0] multiplier;
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] partial;

  // product includes the iteration performed at the current edge, so the
  // caller can capture the final result on the same edge that done is seen.
  assign partial = multiplier[0] ? multiplicand : '0;
  assign product = acc + partial;
  assign done    = active && (count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active       <= 1'b0;
      count        <= '0;
      multiplicand <= '0;
      multiplier   <= '0;
      acc          <= '0;
    end else if (start) begin
      active       <= 1'b1;
      count        <= '0;
      multiplicand <= operand_a;
      multiplier   <= operand_b;
      acc          <= '0;
    end else if (active) begin
      acc          <= product;
      multiplicand <= multiplicand << 1;
      multiplier   <= multiplier >> 1;
      count        <= count + 1'b1;
      if (count == LAST) active <= 1'b0;
    end
  end

endmodule

// File: rtl/execute_unit.sv
// Execute stage: single-cycle ALU plus iterative MUL, writing back to the
// register file through a one-cycle WB strobe.
module execute_unit
  import execute_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iValid,
  input  logic [2:0]            iOperation,
  input  logic [ADDR_WIDTH-1:0] iDestination,
  input  logic [DATA_WIDTH-1:0] iSourceA,
  input  logic [DATA_WIDTH-1:0] iSourceB,
  output logic                  oBusy,
  output logic                  oWriteEnable,
  output logic [ADDR_WIDTH-1:0] oWriteAddress,
  output logic [DATA_WIDTH-1:0] oWriteData,
  output logic                  oCarry,
  output logic                  oZero
);

  state_e                state, state_next;
  op_e                   op;
  logic                  accept;
  logic                  accept_alu;
  logic                  mul_start;
  logic                  mul_done;
  logic [DATA_WIDTH-1:0] mul_product;
  logic [ADDR_WIDTH-1:0] mul_dest;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  alu_carry;
  logic [DATA_WIDTH:0]   sum;

  assign op         = op_e'(iOperation);
  assign accept     = iValid && !oBusy;
  assign mul_start  = accept && (op == OP_MUL);
  assign accept_alu = accept && (op != OP_MUL) && (op != OP_NOP);
  assign sum        = {1'b0, iSourceA} + {1'b0, iSourceB};

  always_comb begin
    alu_result = '0;
    alu_carry  = 1'b0;
    unique case (op)
      OP_ADD: begin
        alu_result = sum[DATA_WIDTH-1:0];
        alu_carry  = sum[DATA_WIDTH];
      end
      OP_SUB: begin
        alu_result = iSourceA - iSourceB;
        alu_carry  = iSourceB > iSourceA;
      end
      OP_AND:  alu_result = iSourceA & iSourceB;
      OP_OR:   alu_result = iSourceA | iSourceB;
      OP_XOR:  alu_result = iSourceA ^ iSourceB;
      OP_SRL:  alu_result = iSourceA >> iSourceB[4:0];
      default: ;
    endcase
  end

  shift_add_multiplier #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mul (
    .clk      (Clock),
    .rst_n    (Reset),
    .start    (mul_start),
    .operand_a(iSourceA),
    .operand_b(iSourceB),
    .done     (mul_done),
    .product  (mul_product)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = S_IDLE;
    unique case (state)
      S_MUL: state_next = mul_done ? S_WB : S_MUL;
      default: begin
        if (accept) begin
          if (op == OP_MUL)      state_next = S_MUL;
          else if (op != OP_NOP) state_next = S_WB;
        end
      end
    endcase
  end

  always_comb begin
    oBusy        = (state == S_MUL);
    oWriteEnable = (state == S_WB);
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      mul_dest      <= '0;
      oWriteAddress <= '0;
      oWriteData    <= '0;
      oCarry        <= 1'b0;
      oZero         <= 1'b0;
    end else begin
      if (mul_start) mul_dest <= iDestination;
      if (accept_alu) begin
        oWriteAddress <= iDestination;
        oWriteData    <= alu_result;
        oCarry        <= alu_carry;
        oZero         <= (alu_result == '0);
      end else if ((state == S_MUL) && mul_done) begin
        oWriteAddress <= mul_dest;
        oWriteData    <= mul_product;
        oCarry        <= 1'b0;
        oZero         <= (mul_product == '0);
      end
    end
  end

endmodule

// File: tb/tb_execute_unit.sv
// Directed self-checking bench for execute_unit (DATA_WIDTH=32, ADDR_WIDTH=8).
module tb_execute_unit;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 8;

  logic          Clock;
  logic          Reset;
  logic          iValid;
  logic [2:0]    iOperation;
  logic [AW-1:0] iDestination;
  logic [DW-1:0] iSourceA;
  logic [DW-1:0] iSourceB;
  logic          oBusy;
  logic          oWriteEnable;
  logic [AW-1:0] oWriteAddress;
  logic [DW-1:0] oWriteData;
  logic          oCarry;
  logic          oZero;

  int checks = 0;
  int errors = 0;

  execute_unit #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .iValid       (iValid),
    .iOperation   (iOperation),
    .iDestination (iDestination),
    .iSourceA     (iSourceA),
    .iSourceB     (iSourceB),
    .oBusy        (oBusy),
    .oWriteEnable (oWriteEnable),
    .oWriteAddress(oWriteAddress),
    .oWriteData   (oWriteData),
    .oCarry       (oCarry),
    .oZero        (oZero)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic drive(input logic v, input logic [2:0] op, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, input logic [AW-1:0] d);
    iValid = v; iOperation = op; iSourceA = a; iSourceB = b; iDestination = d;
  endtask

  task automatic test_reset;
    Reset = 1'b0;
    drive(1'b1, 3'($urandom_range(1, 7)), $urandom, $urandom, 8'($urandom));
    repeat (3) @(negedge Clock);
    checks++;
    if ({oBusy, oWriteEnable, oWriteAddress, oWriteData, oCarry, oZero} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b we=%b addr=%h data=%h c=%b z=%b, want all 0",
               oBusy, oWriteEnable, oWriteAddress, oWriteData, oCarry, oZero);
    end
    drive(1'b0, 3'd0, '0, '0, '0);
    Reset = 1'b1;
    @(negedge Clock);
    checks++;
    if (oWriteEnable !== 1'b0 || oBusy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: got we=%b busy=%b, want 0 0", oWriteEnable, oBusy);
    end
  endtask

  task automatic test_add;
    drive(1'b1, 3'd1, 32'hFFFF_FFFF, 32'd1, 8'd5);
    @(negedge Clock);
    drive(1'b0, 3'd0, '0, '0, '0);
    checks++;
    if ({oWriteEnable, oWriteAddress, oWriteData, oCarry, oZero} !== {1'b1, 8'd5, 32'd0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL add_carry: got we=%b addr=%0d data=%h c=%b z=%b, want 1 5 00000000 1 1",
               oWriteEnable, oWriteAddress, oWriteData, oCarry, oZero);
    end
    @(negedge Clock);
    checks++;
    if ({oWriteEnable, oWriteData, oCarry, oZero} !== {1'b0, 32'd0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL add_hold: got we=%b data=%h c=%b z=%b, want 0 00000000 1 1",
               oWriteEnable, oWriteData, oCarry, oZero);
    end
  endtask

  task automatic test_sub_borrow;
    drive(1'b1, 3'd2, 32'd3, 32'd5, 8'd2);
    @(negedge Clock);
    drive(1'b0, 3'd0, '0, '0, '0);
    checks++;
    if ({oWriteEnable, oWriteAddress, oWriteData, oCarry, oZero} !== {1'b1, 8'd2, 32'hFFFF_FFFE, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL sub_borrow: got we=%b addr=%0d data=%h c=%b z=%b, want 1 2 fffffffe 1 0",
               oWriteEnable, oWriteAddress, oWriteData, oCarry, oZero);
    end
    @(negedge Clock);
  endtask

  task automatic test_mul;
    int busy_cycles = 0;
    drive(1'b1, 3'd7, 32'd1234, 32'd5678, 8'd7);
    @(negedge Clock);
    drive(1'b0, 3'd0, '0, '0, '0);
    while (oBusy === 1'b1 && busy_cycles < 40) begin
      if (oWriteEnable !== 1'b0) begin
        errors++;
        $display("FAIL mul_we_during_busy: got we=%b, want 0", oWriteEnable);
      end
      busy_cycles++;
      @(negedge Clock);
    end
    checks++;
    if (busy_cycles != 32) begin
      errors++;
      $display("FAIL mul_busy_cycles: got %0d, want 32", busy_cycles);
    end
    checks++;
    if ({oBusy, oWriteEnable, oWriteAddress, oWriteData, oCarry, oZero} !== {1'b0, 1'b1, 8'd7, 32'd7006652, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL mul_result: got busy=%b we=%b addr=%0d data=%0d c=%b z=%b, want 0 1 7 7006652 0 0",
               oBusy, oWriteEnable, oWriteAddress, oWriteData, oCarry, oZero);
    end
    @(negedge Clock);
    checks++;
    if (oWriteEnable !== 1'b0) begin
      errors++;
      $display("FAIL mul_single_strobe: got we=%b, want 0", oWriteEnable);
    end
  endtask

  task automatic test_back_to_back;
    int waited = 0;
    drive(1'b1, 3'd5, 32'h0000_F0F0, 32'h0000_FF00, 8'd3);
    @(negedge Clock);
    checks++;
    if ({oWriteEnable, oWriteAddress, oWriteData} !== {1'b1, 8'd3, 32'h0000_0FF0}) begin
      errors++;
      $display("FAIL b2b_xor: got we=%b addr=%0d data=%h, want 1 3 00000ff0",
               oWriteEnable, oWriteAddress, oWriteData);
    end
    drive(1'b1, 3'd3, 32'h0000_F0F0, 32'h0000_FF00, 8'd4);
    @(negedge Clock);
    drive(1'b0, 3'd0, '0, '0, '0);
    checks++;
    if ({oWriteEnable, oWriteAddress, oWriteData} !== {1'b1, 8'd4, 32'h0000_F000}) begin
      errors++;
      $display("FAIL b2b_and: got we=%b addr=%0d data=%h, want 1 4 0000f000",
               oWriteEnable, oWriteAddress, oWriteData);
    end
    @(negedge Clock);
    // MUL followed by an ADD held valid until the block accepts it in WB.
    drive(1'b1, 3'd7, 32'd3, 32'd4, 8'd9);
    @(negedge Clock);
    drive(1'b1, 3'd1, 32'd10, 32'd20, 8'd11);
    while (oWriteEnable !== 1'b1 && waited < 40) begin
      waited++;
      @(negedge Clock);
    end
    checks++;
    if ({oWriteEnable, oWriteAddress, oWriteData} !== {1'b1, 8'd9, 32'd12}) begin
      errors++;
      $display("FAIL b2b_mul_wb: got we=%b addr=%0d data=%0d after %0d cycles, want 1 9 12",
               oWriteEnable, oWriteAddress, oWriteData, waited);
    end
    @(negedge Clock);
    drive(1'b0, 3'd0, '0, '0, '0);
    checks++;
    if ({oWriteEnable, oWriteAddress, oWriteData, oCarry} !== {1'b1, 8'd11, 32'd30, 1'b0}) begin
      errors++;
      $display("FAIL b2b_add_in_wb: got we=%b addr=%0d data=%0d c=%b, want 1 11 30 0",
               oWriteEnable, oWriteAddress, oWriteData, oCarry);
    end
    @(negedge Clock);
    checks++;
    if (oWriteEnable !== 1'b0 || oBusy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_add_once: got we=%b busy=%b, want 0 0", oWriteEnable, oBusy);
    end
  endtask

  task automatic test_nop_srl;
    drive(1'b1, 3'd0, 32'hDEAD_BEEF, 32'd1, 8'd6);
    @(negedge Clock);
    checks++;
    if ({oWriteEnable, oBusy, oWriteAddress} !== {1'b0, 1'b0, 8'd11}) begin
      errors++;
      $display("FAIL nop_no_write: got we=%b busy=%b addr=%0d, want 0 0 11",
               oWriteEnable, oBusy, oWriteAddress);
    end
    drive(1'b1, 3'd6, 32'h8000_0000, 32'd31, 8'd0);
    @(negedge Clock);
    drive(1'b0, 3'd0, '0, '0, '0);
    checks++;
    if ({oWriteEnable, oWriteAddress, oWriteData, oCarry, oZero} !== {1'b1, 8'd0, 32'd1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL srl_31: got we=%b addr=%0d data=%h c=%b z=%b, want 1 0 00000001 0 0",
               oWriteEnable, oWriteAddress, oWriteData, oCarry, oZero);
    end
    @(negedge Clock);
  endtask

  task automatic test_reset_mid_mul;
    drive(1'b1, 3'd7, 32'd100, 32'd100, 8'd12);
    @(negedge Clock);
    drive(1'b0, 3'd0, '0, '0, '0);
    repeat (5) @(negedge Clock);
    checks++;
    if (oBusy !== 1'b1) begin
      errors++;
      $display("FAIL mid_mul_busy: got busy=%b, want 1", oBusy);
    end
    #1 Reset = 1'b0;
    #1;
    checks++;
    if ({oBusy, oWriteEnable, oWriteAddress, oWriteData} !== '0) begin
      errors++;
      $display("FAIL async_reset: got busy=%b we=%b addr=%0d data=%h, want all 0",
               oBusy, oWriteEnable, oWriteAddress, oWriteData);
    end
    @(negedge Clock);
    Reset = 1'b1;
    drive(1'b1, 3'd1, 32'd2, 32'd3, 8'd1);
    @(negedge Clock);
    drive(1'b0, 3'd0, '0, '0, '0);
    checks++;
    if ({oBusy, oWriteEnable, oWriteAddress, oWriteData} !== {1'b0, 1'b1, 8'd1, 32'd5}) begin
      errors++;
      $display("FAIL post_reset_add: got busy=%b we=%b addr=%0d data=%0d, want 0 1 1 5",
               oBusy, oWriteEnable, oWriteAddress, oWriteData);
    end
    repeat (35) begin
      @(negedge Clock);
      if (oWriteEnable !== 1'b0 || oBusy !== 1'b0) begin
        errors++;
        $display("FAIL discarded_mul_write: got we=%b busy=%b addr=%0d, want 0 0",
                 oWriteEnable, oBusy, oWriteAddress);
      end
    end
    checks++;
  endtask

  initial begin
    Reset = 1'b0;
    drive(1'b0, 3'd0, '0, '0, '0);
    @(negedge Clock);
    test_reset();
    test_add();
    test_sub_borrow();
    test_mul();
    test_back_to_back();
    test_nop_srl();
    test_reset_mid_mul();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
